// File: rtl/fp_pkg.sv
// Shared single-precision definitions for the FPU operand front end:
// field widths, operand class encoding and the unpacker FSM state constants.
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int UEXP_W = 10;
    localparam int BIAS   = 127;
    localparam int MANT_W = FRAC_W + 1;

    typedef enum logic [2:0] {
        CLS_ZERO   = 3'd0,
        CLS_DENORM = 3'd1,
        CLS_NORMAL = 3'd2,
        CLS_INF    = 3'd3,
        CLS_QNAN   = 3'd4,
        CLS_SNAN   = 3'd5
    } fp_class_e;

    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t ST_IDLE = 2'd0;
    localparam fsm_state_t ST_NORM = 2'd1;
    localparam fsm_state_t ST_DONE = 2'd2;

    function automatic logic is_nan(input logic [2:0] cls);
        return (cls == CLS_QNAN) || (cls == CLS_SNAN);
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational classifier: splits one packed single-precision word into
// sign, starting exponent, mantissa (hidden bit restored) and operand class.
module fp_classify
    import fp_pkg::*;
(
    input  logic [31:0]       word,
    output logic              sign,
    output logic [UEXP_W-1:0] exp,
    output logic [MANT_W-1:0] mant,
    output logic [2:0]        cls
);

    logic [EXP_W-1:0]  exp_field;
    logic [FRAC_W-1:0] frac_field;

    assign exp_field  = word[30:23];
    assign frac_field = word[22:0];
    assign sign       = word[31];

    // Denormals start at exponent 1 so that each later left shift is paired
    // with a single decrement and the result lands on the true exponent.
    always_comb begin
        exp  = '0;
        mant = '0;
        cls  = CLS_ZERO;
        if (exp_field == '0) begin
            if (frac_field != '0) begin
                cls  = CLS_DENORM;
                mant = {1'b0, frac_field};
                exp  = 10'd1;
            end
        end else if (exp_field == '1) begin
            exp = 10'd255;
            if (frac_field == '0) begin
                cls = CLS_INF;
            end else begin
                cls  = frac_field[FRAC_W-1] ? CLS_QNAN : CLS_SNAN;
                mant = {1'b0, frac_field};
            end
        end else begin
            cls  = CLS_NORMAL;
            mant = {1'b1, frac_field};
            exp  = {2'b00, exp_field};
        end
    end

endmodule

// File: rtl/fp_operand_unpack.sv
// Operand unpacker: classifies two packed operands, normalizes denormals one
// bit per cycle, then presents the aligned fields until the consumer takes them.
module fp_operand_unpack
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       op_a,
    input  logic [31:0]       op_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              a_sign,
    output logic              b_sign,
    output logic [UEXP_W-1:0] a_exp,
    output logic [UEXP_W-1:0] b_exp,
    output logic [MANT_W-1:0] a_mant,
    output logic [MANT_W-1:0] b_mant,
    output logic [2:0]        a_class,
    output logic [2:0]        b_class,
    output logic              invalid_flag,
    output logic              nan_flag,
    output logic [1:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; in_valid is ignored while in_ready is low, and outputs
    // hold steady from out_valid rising until out_ready completes the transfer.
    fsm_state_t state;

    logic              ca_sign, cb_sign;
    logic [UEXP_W-1:0] ca_exp, cb_exp;
    logic [MANT_W-1:0] ca_mant, cb_mant;
    logic [2:0]        ca_cls, cb_cls;

    fp_classify u_classify_a (
        .word (op_a),
        .sign (ca_sign),
        .exp  (ca_exp),
        .mant (ca_mant),
        .cls  (ca_cls)
    );

    fp_classify u_classify_b (
        .word (op_b),
        .sign (cb_sign),
        .exp  (cb_exp),
        .mant (cb_mant),
        .cls  (cb_cls)
    );

    logic a_pend, b_pend, norm_done, any_denorm;

    assign a_pend     = (a_class == CLS_DENORM) && !a_mant[MANT_W-1];
    assign b_pend     = (b_class == CLS_DENORM) && !b_mant[MANT_W-1];
    // Leave NORM on the cycle whose shift brings the last pending operand to bit 23.
    assign norm_done  = (!a_pend || a_mant[MANT_W-2]) && (!b_pend || b_mant[MANT_W-2]);
    assign any_denorm = (ca_cls == CLS_DENORM) || (cb_cls == CLS_DENORM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            a_sign  <= 1'b0;
            b_sign  <= 1'b0;
            a_exp   <= '0;
            b_exp   <= '0;
            a_mant  <= '0;
            b_mant  <= '0;
            a_class <= CLS_ZERO;
            b_class <= CLS_ZERO;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sign  <= ca_sign;
                        b_sign  <= cb_sign;
                        a_exp   <= ca_exp;
                        b_exp   <= cb_exp;
                        a_mant  <= ca_mant;
                        b_mant  <= cb_mant;
                        a_class <= ca_cls;
                        b_class <= cb_cls;
                        state   <= any_denorm ? ST_NORM : ST_DONE;
                    end
                end
                ST_NORM: begin
                    if (a_pend) begin
                        a_mant <= a_mant << 1;
                        a_exp  <= a_exp - 10'd1;
                    end
                    if (b_pend) begin
                        b_mant <= b_mant << 1;
                        b_exp  <= b_exp - 10'd1;
                    end
                    if (norm_done) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready     = (state == ST_IDLE);
    assign out_valid    = (state == ST_DONE);
    assign dbg_state    = state;
    assign nan_flag     = out_valid && (is_nan(a_class) || is_nan(b_class));
    assign invalid_flag = out_valid && ((a_class == CLS_SNAN) || (b_class == CLS_SNAN));

endmodule

// File: tb/tb_fp_operand_unpack.sv
// Bench for fp_operand_unpack: directed operand pairs, randomized pairs against
// an arithmetic reference model, back-pressure, back-to-back and reset abort.
module tb_fp_operand_unpack;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a, op_b;
    logic        out_valid;
    logic        out_ready;
    logic        a_sign, b_sign;
    logic [9:0]  a_exp, b_exp;
    logic [23:0] a_mant, b_mant;
    logic [2:0]  a_class, b_class;
    logic        invalid_flag, nan_flag;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [77:0] exp_q[$];

    fp_operand_unpack dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .op_a         (op_a),
        .op_b         (op_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .a_sign       (a_sign),
        .b_sign       (b_sign),
        .a_exp        (a_exp),
        .b_exp        (b_exp),
        .a_mant       (a_mant),
        .b_mant       (b_mant),
        .a_class      (a_class),
        .b_class      (b_class),
        .invalid_flag (invalid_flag),
        .nan_flag     (nan_flag),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Classes: 0 zero, 1 denorm, 2 normal, 3 inf, 4 qnan, 5 snan.
    task automatic model_op(input logic [31:0] w, output logic s, output logic [9:0] e,
                            output logic [23:0] m, output logic [2:0] c, output int sh);
        logic [7:0]  ef;
        logic [22:0] f;
        int          lz;
        bit          found;
        ef = w[30:23];
        f  = w[22:0];
        s  = w[31];
        sh = 0;
        lz = 0;
        found = 1'b0;
        if (ef == 8'd0 && f == 23'd0) begin
            e = 10'd0; m = 24'd0; c = 3'd0;
        end else if (ef == 8'd0) begin
            for (int i = 22; i >= 0; i--) begin
                if (!found) begin
                    if (f[i]) found = 1'b1;
                    else lz++;
                end
            end
            sh = lz + 1;
            e  = 10'(1 - sh);
            m  = 24'(32'(f) * (32'd1 << sh));
            c  = 3'd1;
        end else if (ef == 8'd255) begin
            e = 10'd255;
            m = (f == 23'd0) ? 24'd0 : {1'b0, f};
            c = (f == 23'd0) ? 3'd3 : (f[22] ? 3'd4 : 3'd5);
        end else begin
            e = {2'b00, ef};
            m = {1'b1, f};
            c = 3'd2;
        end
    endtask

    task automatic expect_pair(input logic [31:0] a, input logic [31:0] b,
                               output logic [77:0] v, output int lat);
        logic as, bs;
        logic [9:0] ae, be;
        logic [23:0] am, bm;
        logic [2:0] ac, bc;
        int sa, sb;
        logic nan, inv;
        model_op(a, as, ae, am, ac, sa);
        model_op(b, bs, be, bm, bc, sb);
        nan = (ac >= 3'd4) || (bc >= 3'd4);
        inv = (ac == 3'd5) || (bc == 3'd5);
        v   = {as, ae, am, ac, bs, be, bm, bc, inv, nan};
        lat = 1 + ((sa > sb) ? sa : sb);
    endtask

    function automatic logic [77:0] obs_vec();
        return {a_sign, a_exp, a_mant, a_class, b_sign, b_exp, b_mant, b_class,
                invalid_flag, nan_flag};
    endfunction

    function automatic logic [31:0] gen_op(input int kind);
        logic        s;
        logic [22:0] f;
        logic [21:0] r;
        s = 1'($urandom_range(0, 1));
        case (kind)
            0: gen_op = {s, 8'h00, 23'h0};
            1: begin
                f = 23'($urandom_range(1, 32'h7FFFFF) >> $urandom_range(0, 22));
                if (f == 23'd0) f = 23'd1;
                gen_op = {s, 8'h00, f};
            end
            3: gen_op = {s, 8'hFF, 23'h0};
            4: gen_op = {s, 8'hFF, 1'b1, 22'($urandom)};
            5: begin
                r = 22'($urandom);
                if (r == 22'd0) r = 22'd1;
                gen_op = {s, 8'hFF, 1'b0, r};
            end
            default: gen_op = {s, 8'($urandom_range(1, 254)), 23'($urandom)};
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    // Called at posedge+1 with out_ready high; returns at posedge+1 after the output handshake.
    task automatic run_pair(input logic [31:0] a, input logic [31:0] b,
                            output logic [77:0] obs, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        op_a = a;
        op_b = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        obs = obs_vec();
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        op_a = '0;
        op_b = '0;
        #12;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++;
        if (obs_vec() !== 78'd0) begin n_fail++; $display("FAIL reset_outputs got %h want 0", obs_vec()); end
        n_checks++;
        if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", dbg_state); end
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] ta[4] = '{32'h3F800000, 32'h00400000, 32'h7F800000, 32'h80000000};
        logic [31:0] tb[4] = '{32'hC0000000, 32'h00000001, 32'h7FA00000, 32'h7FC00000};
        int          w_lat[4]    = '{1, 24, 1, 1};
        logic [9:0]  w_aexp[4]   = '{10'd127, 10'd0, 10'd255, 10'd0};
        logic [9:0]  w_bexp[4]   = '{10'd128, 10'h3EA, 10'd255, 10'd255};
        logic [23:0] w_amant[4]  = '{24'h800000, 24'h800000, 24'h0, 24'h0};
        logic [23:0] w_bmant[4]  = '{24'h800000, 24'h800000, 24'h200000, 24'h400000};
        logic [2:0]  w_acls[4]   = '{3'd2, 3'd1, 3'd3, 3'd0};
        logic [2:0]  w_bcls[4]   = '{3'd2, 3'd1, 3'd5, 3'd4};
        logic [1:0]  w_sign[4]   = '{2'b01, 2'b00, 2'b00, 2'b10};
        logic [1:0]  w_flags[4]  = '{2'b00, 2'b00, 2'b11, 2'b01};
        logic [77:0] obs, mv;
        int          lat, mlat;
        for (int i = 0; i < 4; i++) begin
            run_pair(ta[i], tb[i], obs, lat);
            expect_pair(ta[i], tb[i], mv, mlat);
            n_checks++;
            if (lat !== w_lat[i]) begin n_fail++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, w_lat[i]); end
            n_checks++;
            if (obs[76:67] !== w_aexp[i]) begin n_fail++; $display("FAIL dir%0d_a_exp got %h want %h", i, obs[76:67], w_aexp[i]); end
            n_checks++;
            if (obs[38:29] !== w_bexp[i]) begin n_fail++; $display("FAIL dir%0d_b_exp got %h want %h", i, obs[38:29], w_bexp[i]); end
            n_checks++;
            if (obs[66:43] !== w_amant[i]) begin n_fail++; $display("FAIL dir%0d_a_mant got %h want %h", i, obs[66:43], w_amant[i]); end
            n_checks++;
            if (obs[28:5] !== w_bmant[i]) begin n_fail++; $display("FAIL dir%0d_b_mant got %h want %h", i, obs[28:5], w_bmant[i]); end
            n_checks++;
            if ({obs[42:40], obs[4:2]} !== {w_acls[i], w_bcls[i]}) begin n_fail++; $display("FAIL dir%0d_classes got %0d/%0d want %0d/%0d", i, obs[42:40], obs[4:2], w_acls[i], w_bcls[i]); end
            n_checks++;
            if ({obs[77], obs[39]} !== w_sign[i]) begin n_fail++; $display("FAIL dir%0d_signs got %b want %b", i, {obs[77], obs[39]}, w_sign[i]); end
            n_checks++;
            if (obs[1:0] !== w_flags[i]) begin n_fail++; $display("FAIL dir%0d_inv_nan got %b want %b", i, obs[1:0], w_flags[i]); end
            n_checks++;
            if (obs !== mv || lat !== mlat) begin n_fail++; $display("FAIL dir%0d_model got %h/%0d want %h/%0d", i, obs, lat, mv, mlat); end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic [77:0] obs, mv;
        int          lat, mlat, ka, kb;
        for (int i = 0; i < 60; i++) begin
            ka = $urandom_range(0, 7);
            kb = $urandom_range(0, 7);
            a = gen_op((ka > 5) ? 1 : ka);
            b = gen_op((kb > 5) ? 1 : kb);
            run_pair(a, b, obs, lat);
            expect_pair(a, b, mv, mlat);
            n_checks++;
            if (obs !== mv) begin n_fail++; $display("FAIL rand%0d_fields a=%h b=%h got %h want %h", i, a, b, obs, mv); end
            n_checks++;
            if (lat !== mlat) begin n_fail++; $display("FAIL rand%0d_latency a=%h b=%h got %0d want %0d", i, a, b, lat, mlat); end
        end
    endtask

    task automatic test_back_pressure();
        logic [77:0] snap, mv;
        int          lat, mlat;
        out_ready = 1'b0;
        op_a = 32'h3F800000;
        op_b = 32'h00000100;
        in_valid = 1'b1;
        @(posedge clk); #1;
        expect_pair(32'h3F800000, 32'h00000100, mv, mlat);
        op_a = $urandom;
        op_b = $urandom;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        snap = obs_vec();
        n_checks++;
        if (snap !== mv || lat !== mlat) begin n_fail++; $display("FAIL bp_first got %h/%0d want %h/%0d", snap, lat, mv, mlat); end
        for (int i = 0; i < 10; i++) begin
            op_a = $urandom;
            op_b = $urandom;
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid, in_ready} !== 2'b10) begin n_fail++; $display("FAIL bp_hold%0d valid/ready got %b want 10", i, {out_valid, in_ready}); end
            n_checks++;
            if (obs_vec() !== snap) begin n_fail++; $display("FAIL bp_stable%0d got %h want %h", i, obs_vec(), snap); end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_release valid/ready got %b want 01", {out_valid, in_ready}); end
    endtask

    task automatic test_back_to_back();
        localparam int N = 12;
        logic [77:0] e;
        int          n_acc, n_out, cyc, l;
        logic        acc, hs;
        n_acc = 0; n_out = 0; cyc = 0;
        out_ready = 1'b1;
        op_a = gen_op($urandom_range(2, 5));
        op_b = gen_op($urandom_range(0, 5) == 1 ? 2 : $urandom_range(2, 5));
        in_valid = 1'b1;
        while (n_out < N && cyc < 500) begin
            acc = in_valid && in_ready;
            hs  = out_valid && out_ready;
            if (hs) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_unexpected got %h want none", obs_vec());
                end else begin
                    e = exp_q.pop_front();
                    if (obs_vec() !== e) begin n_fail++; $display("FAIL b2b_out%0d got %h want %h", n_out, obs_vec(), e); end
                end
                n_out++;
            end
            if (acc) begin
                expect_pair(op_a, op_b, e, l);
                exp_q.push_back(e);
                n_acc++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                if (n_acc < N) begin
                    op_a = gen_op($urandom_range(2, 5));
                    op_b = gen_op($urandom_range(0, 1) == 1 ? 0 : $urandom_range(2, 5));
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (n_out !== N) begin n_fail++; $display("FAIL b2b_count got %0d want %0d", n_out, N); end
        n_checks++;
        if (cyc !== 2 * N) begin n_fail++; $display("FAIL b2b_cycles got %0d want %0d", cyc, 2 * N); end
    endtask

    task automatic test_reset_mid_norm();
        logic [77:0] obs, mv;
        int          lat, mlat;
        op_a = 32'h3F800000;
        op_b = 32'h00000001;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if ({out_valid, in_ready} !== 2'b00) begin n_fail++; $display("FAIL rstnorm_busy valid/ready got %b want 00", {out_valid, in_ready}); end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL rstnorm_abort valid/ready got %b want 01", {out_valid, in_ready}); end
        n_checks++;
        if (obs_vec() !== 78'd0) begin n_fail++; $display("FAIL rstnorm_clear got %h want 0", obs_vec()); end
        #2 rst = 1'b0;
        @(posedge clk); #1;
        run_pair(32'h00400000, 32'h3F800000, obs, lat);
        expect_pair(32'h00400000, 32'h3F800000, mv, mlat);
        n_checks++;
        if (obs !== mv) begin n_fail++; $display("FAIL rstnorm_next got %h want %h", obs, mv); end
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL rstnorm_next_latency got %0d want 2", lat); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_pressure();
        test_back_to_back();
        test_reset_mid_norm();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL leftover_expected got %0d want 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
